pc_sequencer: RTL and testbench

//  Multicycle controller for the PC apparatus. Drives the PC register enable and the next-PC select,
//  and issues the instruction-fetch handshake. Sequences FETCH->DECODE->EXEC->UPDATE once per instruction.

---
 rtl/pc_sequencer_pkg.sv | 16 +
 rtl/pc_sequencer_watchdog.sv | 19 +
 rtl/pc_sequencer.sv | 78 +++++++
 tb/tb_pc_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: next-PC selects, branch classes and sequencer state encodings
package pc_sequencer_pkg;
  localparam logic [1:0] PCSEL_PCPLUSFOUR = 2'b00;
  localparam logic [1:0] PCSEL_PCOFFSET   = 2'b01;
  localparam logic [1:0] PCSEL_REGOFFSET  = 2'b10;
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_REG  = 2'b10;
  localparam logic [1:0] BR_BAD  = 2'b11;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALT, S_FAULT
  } state_e;
  function automatic logic [1:0] br_to_pcsel(input logic [1:0] br);
    return br == BR_COND ? PCSEL_PCOFFSET : br == BR_REG ? PCSEL_REGOFFSET : PCSEL_PCPLUSFOUR;
  endfunction
endpackage

// File: rtl/pc_sequencer_watchdog.sv
// fetch_watchdog: counts unanswered fetch-request cycles and flags the one that exhausts MEM_TIMEOUT
module fetch_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic count_i,
  output logic expire_o
);
  localparam int W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? '0 : count_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // MEM_TIMEOUT of 0 leaves the counter free-running but never lets it expire
  assign expire_o = (MEM_TIMEOUT != 0) && count_i && !clear_i && cnt_q == W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle FETCH/DECODE/EXEC/UPDATE controller driving the PC register and fetch port
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_BITS    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  output logic                imemReq,
  input  logic                imemAck,
  output logic                irLoad,
  input  logic                exDone,
  input  logic [1:0]          brType,
  input  logic                cmp,
  input  logic                halt,
  output logic                pcEnable,
  output logic [1:0]          pcSel,
  output logic                cmpOut,
  output logic                halted,
  output logic                fault,
  output logic [CNT_BITS-1:0] retireCount
);
  state_e state_q, state_d;
  logic [1:0] br_q, br_d;
  logic cmp_q, cmp_d;
  logic [CNT_BITS-1:0] ret_q, ret_d;
  logic expire;
  fetch_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
    .clk(clk), .reset(reset), .clear_i(state_q != S_FETCH),
    .count_i(imemReq && !imemAck), .expire_o(expire)
  );
  assign imemReq     = state_q == S_FETCH && !stall;
  assign irLoad      = imemReq && imemAck;
  assign pcEnable    = state_q == S_UPDATE;
  assign pcSel       = br_to_pcsel(br_q);
  assign cmpOut      = cmp_q;
  assign halted      = state_q == S_HALT;
  assign fault       = state_q == S_FAULT;
  assign retireCount = ret_q;
  always_comb begin
    state_d = state_q;
    br_d    = br_q;
    cmp_d   = cmp_q;
    ret_d   = ret_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = irLoad ? S_DECODE : expire ? S_FAULT : S_FETCH;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:
        if (exDone) begin
          state_d = halt ? S_HALT : brType == BR_BAD ? S_FAULT : S_UPDATE;
          if (!halt && brType != BR_BAD) begin
            br_d  = brType;
            cmp_d = cmp;
          end
        end
      S_UPDATE: begin
        state_d = S_FETCH;
        ret_d   = ret_q + 1'b1;
      end
      default:  state_d = state_q;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      br_q    <= BR_NONE;
      cmp_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      br_q    <= br_d;
      cmp_q   <= cmp_d;
      ret_q   <= ret_d;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table, hand-written corner sequences and random traffic against a phase-level model
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;
  localparam int TO = 16;
  localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3, P_UPD = 4, P_HALT = 5, P_FAULT = 6;
  logic clk = 0, reset = 0, stall = 0, imem_ack = 0, ex_done = 0, cmp = 0, halt = 0;
  logic [1:0] br = 0;
  logic imem_req, ir_load, pc_enable, cmp_out, halted, fault;
  logic [1:0] pc_sel;
  logic [31:0] retire;
  logic d4_req, d4_ir, d4_pe, d4_cmpo, d4_halted, d4_fault;
  logic [1:0] d4_sel;
  logic [3:0] d4_ret;
  logic [7:0] flags, flags4;
  assign flags  = {imem_req, ir_load, pc_enable, pc_sel, cmp_out, halted, fault};
  assign flags4 = {d4_req, d4_ir, d4_pe, d4_sel, d4_cmpo, d4_halted, d4_fault};
  pc_sequencer #(.MEM_TIMEOUT(TO), .CNT_BITS(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .imemReq(imem_req), .imemAck(imem_ack),
    .irLoad(ir_load), .exDone(ex_done), .brType(br), .cmp(cmp), .halt(halt),
    .pcEnable(pc_enable), .pcSel(pc_sel), .cmpOut(cmp_out), .halted(halted),
    .fault(fault), .retireCount(retire)
  );
  pc_sequencer #(.MEM_TIMEOUT(TO), .CNT_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .imemReq(d4_req), .imemAck(imem_ack),
    .irLoad(d4_ir), .exDone(ex_done), .brType(br), .cmp(cmp), .halt(halt),
    .pcEnable(d4_pe), .pcSel(d4_sel), .cmpOut(d4_cmpo), .halted(d4_halted),
    .fault(d4_fault), .retireCount(d4_ret)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: which phase of the instruction we are in, how long the current fetch has gone unanswered,
  // the last committed branch class/compare, and how many instructions have retired.
  int ph, waitc;
  logic [1:0] m_br;
  logic m_cmp;
  longint unsigned m_ret;
  task automatic mreset();
    ph = P_IDLE; waitc = 0; m_br = 2'b00; m_cmp = 1'b0; m_ret = 0;
  endtask
  function automatic logic [7:0] m_out();
    logic r;
    logic [1:0] s;
    r = ph == P_FETCH && !stall;
    s = m_br == BR_COND ? PCSEL_PCOFFSET : m_br == BR_REG ? PCSEL_REGOFFSET : PCSEL_PCPLUSFOUR;
    return {r, r && imem_ack, ph == P_UPD, s, m_cmp, ph == P_HALT, ph == P_FAULT};
  endfunction
  task automatic mupdate();
    if (!reset) begin
      mreset();
      return;
    end
    case (ph)
      P_IDLE: begin ph = P_FETCH; waitc = 0; end
      P_FETCH:
        if (!stall) begin
          if (imem_ack) ph = P_DEC;
          else begin
            waitc++;
            if (TO != 0 && waitc == TO) ph = P_FAULT;
          end
        end
      P_DEC: ph = P_EXEC;
      P_EXEC:
        if (ex_done) begin
          if (halt) ph = P_HALT;
          else if (br == 2'b11) ph = P_FAULT;
          else begin m_br = br; m_cmp = cmp; ph = P_UPD; end
        end
      P_UPD: begin m_ret++; ph = P_FETCH; waitc = 0; end
      default: ;
    endcase
  endtask
  task automatic mcheck();
    if (!reset) mreset();
    chk("outputs", 32'(flags), 32'(m_out()));
    chk("outputs_cnt4", 32'(flags4), 32'(m_out()));
    chk("retire32", retire, m_ret[31:0]);
    chk("retire4", 32'(d4_ret), 32'(4'(m_ret)));
  endtask
  task automatic tick();
    @(negedge clk);
    mcheck();
    @(posedge clk);
    mupdate();
    #1;
  endtask
  task automatic go_reset();
    stall = 0; imem_ack = 0; ex_done = 0; br = 0; cmp = 0; halt = 0;
    reset = 0;
    tick();
    reset = 1;
    tick();
  endtask
  task automatic to_exec();
    imem_ack = 1; tick();
    imem_ack = 0; tick();
  endtask
  task automatic fast_instr(input logic [1:0] b, input logic c);
    to_exec();
    ex_done = 1; br = b; cmp = c; tick();
    ex_done = 0; br = 0; cmp = 0; tick();
  endtask
  typedef struct {
    logic stall, ack, done;
    logic [1:0] br;
    logic cmp, halt;
    logic [7:0] exp;
    logic [31:0] ret;
  } vec_t;
  function automatic vec_t mk(input logic s, a, d, input logic [1:0] b, input logic c, h,
                              input logic [7:0] e, input logic [31:0] r);
    vec_t v;
    v.stall = s; v.ack = a; v.done = d; v.br = b; v.cmp = c; v.halt = h; v.exp = e; v.ret = r;
    return v;
  endfunction
  vec_t tv[26];
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    int nreq, cyc, pe_seen, stuck;
    logic slow;
    // expected flags = {imemReq, irLoad, pcEnable, pcSel[1:0], cmpOut, halted, fault}
    tv[0]  = mk(0,0,0,2'd0,0,0, 8'b0000_0000, 0);
    tv[1]  = mk(0,1,0,2'd0,0,0, 8'b1100_0000, 0);
    tv[2]  = mk(0,0,0,2'd0,0,0, 8'b0000_0000, 0);
    tv[3]  = mk(0,0,1,2'd0,0,0, 8'b0000_0000, 0);
    tv[4]  = mk(0,0,0,2'd0,0,0, 8'b0010_0000, 0);
    tv[5]  = mk(0,1,0,2'd0,0,0, 8'b1100_0000, 1);
    tv[6]  = mk(0,0,0,2'd0,0,0, 8'b0000_0000, 1);
    tv[7]  = mk(0,0,1,2'd0,0,0, 8'b0000_0000, 1);
    tv[8]  = mk(0,0,0,2'd0,0,0, 8'b0010_0000, 1);
    tv[9]  = mk(0,1,0,2'd0,0,0, 8'b1100_0000, 2);
    tv[10] = mk(0,0,0,2'd0,0,0, 8'b0000_0000, 2);
    tv[11] = mk(0,0,1,2'd0,0,0, 8'b0000_0000, 2);
    tv[12] = mk(0,0,0,2'd0,0,0, 8'b0010_0000, 2);
    tv[13] = mk(0,1,0,2'd0,0,0, 8'b1100_0000, 3);
    tv[14] = mk(0,0,0,2'd0,0,0, 8'b0000_0000, 3);
    tv[15] = mk(0,0,1,2'd1,1,0, 8'b0000_0000, 3);
    tv[16] = mk(0,0,0,2'd0,0,0, 8'b0010_1100, 3);
    tv[17] = mk(0,1,0,2'd0,0,0, 8'b1100_1100, 4);
    tv[18] = mk(0,0,0,2'd0,0,0, 8'b0000_1100, 4);
    tv[19] = mk(0,0,1,2'd1,0,0, 8'b0000_1100, 4);
    tv[20] = mk(0,0,0,2'd0,0,0, 8'b0010_1000, 4);
    tv[21] = mk(0,1,0,2'd0,0,0, 8'b1100_1000, 5);
    tv[22] = mk(0,0,0,2'd0,0,0, 8'b0000_1000, 5);
    tv[23] = mk(0,0,1,2'd2,1,0, 8'b0000_1000, 5);
    tv[24] = mk(0,0,0,2'd0,0,0, 8'b0011_0100, 5);
    tv[25] = mk(1,1,0,2'd0,0,0, 8'b0001_0100, 6);
    mreset();
    tick();
    chk("reset_state", 32'(flags), 32'd0);
    chk("reset_retire", retire, 32'd0);
    reset = 1;
    for (int i = 0; i < 26; i++) begin
      stall = tv[i].stall; imem_ack = tv[i].ack; ex_done = tv[i].done;
      br = tv[i].br; cmp = tv[i].cmp; halt = tv[i].halt;
      @(negedge clk);
      mcheck();
      chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(tv[i].exp));
      chk($sformatf("vec%0d_retire", i), retire, tv[i].ret);
      @(posedge clk);
      mupdate();
      #1;
    end
    // stalled fetch ignores ack and does not age the watchdog
    go_reset();
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      imem_ack = i[0];
      tick();
      chk("stall_noreq", 32'({imem_req, ir_load}), 32'd0);
    end
    stall = 0; imem_ack = 0;
    repeat (TO - 1) tick();
    chk("stall_no_fault", 32'({fault, imem_req}), 32'b01);
    imem_ack = 1; tick();
    imem_ack = 0;
    chk("stall_resume_decode", 32'({fault, imem_req}), 32'd0);
    tick();
    // watchdog expiry
    go_reset();
    nreq = 0; cyc = 0;
    while (!fault && cyc < 40) begin
      if (imem_req) nreq++;
      tick();
      cyc++;
    end
    chk("timeout_cycles", 32'(cyc), 32'(TO));
    chk("timeout_req_cycles", 32'(nreq), 32'(TO));
    repeat (4) begin
      tick();
      chk("fault_no_req", 32'({fault, imem_req}), 32'b10);
    end
    // HALT wins over BR_REG and never updates the PC
    go_reset();
    to_exec();
    ex_done = 1; halt = 1; br = BR_REG; tick();
    ex_done = 0; halt = 0; br = 0; imem_ack = 1;
    pe_seen = 0;
    repeat (6) begin
      if (pc_enable) pe_seen++;
      tick();
    end
    imem_ack = 0;
    chk("halt_flags", 32'({halted, fault}), 32'b10);
    chk("halt_no_pcenable", 32'(pe_seen), 32'd0);
    // illegal branch class
    go_reset();
    to_exec();
    ex_done = 1; br = 2'b11; tick();
    ex_done = 0; br = 0;
    chk("brbad_fault", 32'({halted, fault}), 32'b01);
    tick(); tick();
    chk("brbad_sticky", 32'(fault), 32'd1);
    // reset in EXEC
    go_reset();
    fast_instr(BR_COND, 1);
    fast_instr(BR_REG, 1);
    to_exec();
    tick();
    reset = 0; #1;
    chk("rst_exec_flags", 32'(flags), 32'd0);
    chk("rst_exec_retire", retire, 32'd0);
    tick();
    reset = 1; tick();
    chk("rst_exec_restart", 32'(imem_req), 32'd1);
    fast_instr(BR_NONE, 0);
    chk("rst_exec_retire1", retire, 32'd1);
    // reset in UPDATE
    to_exec();
    ex_done = 1; br = BR_COND; cmp = 1; tick();
    ex_done = 0; br = 0; cmp = 0;
    chk("upd_pcenable", 32'({pc_enable, pc_sel, cmp_out}), 32'b1011);
    reset = 0; #1;
    chk("rst_upd_flags", 32'(flags), 32'd0);
    chk("rst_upd_retire", retire, 32'd0);
    tick();
    reset = 1; tick();
    fast_instr(BR_NONE, 0);
    chk("rst_upd_retire1", retire, 32'd1);
    // counter wrap on the 4-bit instance
    go_reset();
    repeat (17) fast_instr(BR_NONE, 0);
    chk("wrap_retire32", retire, 32'd17);
    chk("wrap_retire4", 32'(d4_ret), 32'd1);
    // random traffic
    go_reset();
    stuck = 0; slow = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) slow = ~slow;
      stuck = (halted || fault) ? stuck + 1 : 0;
      reset = ($urandom_range(0, 199) != 0) && stuck < 4;
      stall = $urandom_range(0, 3) == 0;
      imem_ack = slow ? $urandom_range(0, 19) == 0 : $urandom_range(0, 1) == 1;
      ex_done = $urandom_range(0, 1) == 1;
      br = $urandom_range(0, 15) == 0 ? 2'b11 : 2'($urandom_range(0, 2));
      cmp = $urandom_range(0, 1) == 1;
      halt = $urandom_range(0, 31) == 0;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
